// File: rtl/inst_queue_pkg.sv
// Shared types for the instruction fetch front end: handshake bundles, FIFO entry and FSM states.
package inst_queue_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [XLEN-1:0] UIntX;
    typedef logic [XLEN-1:0] Addr;

    typedef struct packed {
        logic valid;
        Addr  addr;
    } IReq;

    // Response to the core; its ready travels on a separate input.
    typedef struct packed {
        logic        valid;
        Addr         addr;
        logic [31:0] inst;
        Addr         pred_next;
    } IResp;

    // Read request to the I-cache; its ready travels on a separate input.
    typedef struct packed {
        logic valid;
        Addr  addr;
        logic wen;
        UIntX wdata;
    } CacheReq;

    typedef struct packed {
        logic valid;
        UIntX rdata;
    } CacheResp;

    typedef struct packed {
        logic valid;
        Addr  pc;
        logic taken;
        Addr  target;
    } BrInfo;

    typedef struct packed {
        Addr         addr;
        logic [31:0] inst;
        Addr         pred_next;
    } FetchEntry;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDiscard
    } fetch_state_e;

endpackage

// File: rtl/inst_fifo.sv
// Circular buffer of fetched instructions with flush; push into a full FIFO is legal only with a pop.
module inst_fifo
    import inst_queue_pkg::*;
#(
    parameter int unsigned Depth = 4,
    localparam int unsigned CntW = $clog2(Depth) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            push_i,
    input  FetchEntry       push_data_i,
    input  logic            pop_i,
    output FetchEntry       head_o,
    output logic [CntW-1:0] count_o,
    output logic            empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    FetchEntry       mem_q [Depth];
    logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0] count_q;
    logic            do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CntW'(Depth)) || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/inst_queue.sv
// Fetch front end: BTB-predicted PC generation, one outstanding I-cache read, in-order FIFO to core.
// Response/request ready signals are separate inputs because a packed struct has one direction.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int unsigned Depth      = 4,
    parameter int unsigned BtbEntries = 16,
    parameter Addr         ResetPc    = '0
) (
    input  logic     clk,
    input  logic     rst_n,
    input  IReq      ireq,
    output IResp     iresp,
    input  logic     iresp_ready,
    output CacheReq  memreq,
    input  logic     memreq_ready,
    input  CacheResp memresp,
    input  BrInfo    brinfo
);

    localparam int unsigned IdxW = $clog2(BtbEntries);
    localparam int unsigned TagW = XLEN - 2 - IdxW;
    localparam int unsigned CntW = $clog2(Depth) + 1;

    fetch_state_e state_q, state_d;
    Addr          pc_q, pc_d;
    logic         run_q;

    logic            btb_valid_q  [BtbEntries];
    logic [TagW-1:0] btb_tag_q    [BtbEntries];
    Addr             btb_target_q [BtbEntries];
    logic [1:0]      btb_ctr_q    [BtbEntries];

    logic [IdxW-1:0] pc_idx, br_idx;
    logic [TagW-1:0] pc_tag, br_tag;
    logic            btb_hit, br_match;
    Addr             pred_next;

    logic            redirect, issue;
    logic            fifo_push, fifo_pop, fifo_empty;
    logic [CntW-1:0] fifo_count;
    FetchEntry       fifo_head, fifo_wdata;
    logic            unused_lsb;

    // Prediction: strongly/weakly taken entries (ctr >= 2) redirect to the stored target.
    assign pc_idx    = pc_q[2 +: IdxW];
    assign pc_tag    = pc_q[XLEN-1 -: TagW];
    assign btb_hit   = btb_valid_q[pc_idx] && (btb_tag_q[pc_idx] == pc_tag) && btb_ctr_q[pc_idx][1];
    assign pred_next = btb_hit ? btb_target_q[pc_idx] : pc_q + Addr'(4);

    assign br_idx     = brinfo.pc[2 +: IdxW];
    assign br_tag     = brinfo.pc[XLEN-1 -: TagW];
    assign br_match   = btb_valid_q[br_idx] && (btb_tag_q[br_idx] == br_tag);
    assign unused_lsb = ^brinfo.pc[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(BtbEntries); i++) begin
                btb_valid_q[i]  <= 1'b0;
                btb_tag_q[i]    <= '0;
                btb_target_q[i] <= '0;
                btb_ctr_q[i]    <= 2'd0;
            end
        end else if (brinfo.valid) begin
            if (br_match) begin
                if (brinfo.taken) begin
                    if (btb_ctr_q[br_idx] != 2'd3) btb_ctr_q[br_idx] <= btb_ctr_q[br_idx] + 2'd1;
                    btb_target_q[br_idx] <= brinfo.target;
                end else if (btb_ctr_q[br_idx] != 2'd0) begin
                    btb_ctr_q[br_idx] <= btb_ctr_q[br_idx] - 2'd1;
                end
            end else if (brinfo.taken) begin
                btb_valid_q[br_idx]  <= 1'b1;
                btb_tag_q[br_idx]    <= br_tag;
                btb_target_q[br_idx] <= brinfo.target;
                btb_ctr_q[br_idx]    <= 2'd2;
            end
        end
    end

    assign redirect = ireq.valid;
    // run_q keeps memreq low for the first cycle out of reset.
    assign issue    = run_q && (state_q == StIdle) && (fifo_count < CntW'(Depth)) && !redirect;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        fifo_push = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (issue && memreq_ready) state_d = StWait;
            end
            StWait: begin
                // A redirect coinciding with the response drops it; nothing is left pending.
                if (memresp.valid) begin
                    state_d = StIdle;
                    if (!redirect) begin
                        fifo_push = 1'b1;
                        pc_d      = pred_next;
                    end
                end else if (redirect) begin
                    state_d = StDiscard;
                end
            end
            StDiscard: begin
                if (memresp.valid) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (redirect) pc_d = ireq.addr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pc_q    <= ResetPc;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            run_q   <= 1'b1;
        end
    end

    assign fifo_wdata = '{addr: pc_q, inst: memresp.rdata[31:0], pred_next: pred_next};
    assign fifo_pop   = iresp.valid && iresp_ready;

    inst_fifo #(
        .Depth (Depth)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (redirect),
        .push_i      (fifo_push),
        .push_data_i (fifo_wdata),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty)
    );

    assign iresp.valid     = !fifo_empty && !redirect;
    assign iresp.addr      = fifo_head.addr;
    assign iresp.inst      = fifo_head.inst;
    assign iresp.pred_next = fifo_head.pred_next;

    assign memreq.valid = issue;
    assign memreq.addr  = pc_q;
    assign memreq.wen   = 1'b0;
    assign memreq.wdata = '0;

endmodule

// File: tb/tb_inst_queue.sv
// Randomized bench: queue-based reference model feeds a scoreboard checked by a separate monitor.
module tb_inst_queue;
    import inst_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int BTB   = 16;

    logic     clk = 1'b0;
    logic     rst_n;
    IReq      ireq;
    IResp     iresp;
    logic     iresp_ready;
    CacheReq  memreq;
    logic     memreq_ready;
    CacheResp memresp;
    BrInfo    brinfo;

    inst_queue #(
        .Depth      (DEPTH),
        .BtbEntries (BTB),
        .ResetPc    (32'h0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ireq         (ireq),
        .iresp        (iresp),
        .iresp_ready  (iresp_ready),
        .memreq       (memreq),
        .memreq_ready (memreq_ready),
        .memresp      (memresp),
        .brinfo       (brinfo)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Reference model: fetch PC, queued instructions, one outstanding read, predictor table.
    FetchEntry sb_q[$];
    Addr       m_pc      = 32'h0;
    int        m_cnt     = 0;
    bit        m_run     = 0;
    bit        m_busy    = 0;
    bit        m_drop    = 0;
    Addr       m_rd_addr = 32'h0;
    int        m_delay   = 0;
    bit        b_valid [BTB];
    Addr       b_tag   [BTB];
    Addr       b_tgt   [BTB];
    int        b_ctr   [BTB];

    function automatic Addr mem_data(input Addr a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    function automatic Addr predict(input Addr pc);
        int i = int'((pc >> 2) % BTB);
        if (b_valid[i] && b_tag[i] == (pc >> 6) && b_ctr[i] >= 2) return b_tgt[i];
        return pc + 32'd4;
    endfunction

    function automatic void train();
        int  i   = int'((brinfo.pc >> 2) % BTB);
        Addr tag = brinfo.pc >> 6;
        if (!brinfo.valid) return;
        if (b_valid[i] && b_tag[i] == tag) begin
            if (brinfo.taken) begin
                b_ctr[i] = (b_ctr[i] < 3) ? b_ctr[i] + 1 : 3;
                b_tgt[i] = brinfo.target;
            end else begin
                b_ctr[i] = (b_ctr[i] > 0) ? b_ctr[i] - 1 : 0;
            end
        end else if (brinfo.taken) begin
            b_valid[i] = 1;
            b_tag[i]   = tag;
            b_tgt[i]   = brinfo.target;
            b_ctr[i]   = 2;
        end
    endfunction

    function automatic Addr rand_addr();
        if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFF0 + {$urandom_range(0, 3), 2'b00};
        return Addr'({$urandom_range(0, 47), 2'b00});
    endfunction

    // Apply the inputs held during the cycle that just ended.
    task automatic model_update();
        Addr pred = predict(m_pc);
        bit  pop  = (m_cnt > 0) && !ireq.valid && iresp_ready;
        bit  resp = memresp.valid && m_busy;
        if (ireq.valid) begin
            sb_q.delete();
            m_cnt = 0;
            m_pc  = ireq.addr;
            if (resp) begin
                m_busy = 0;
                m_drop = 0;
            end else if (m_busy) begin
                m_drop = 1;
            end
        end else begin
            if (resp) begin
                if (!m_drop) begin
                    sb_q.push_back('{addr: m_pc, inst: mem_data(m_pc), pred_next: pred});
                    m_cnt++;
                    m_pc = pred;
                end
                m_busy = 0;
                m_drop = 0;
            end else if (!m_busy && m_run && m_cnt < DEPTH && memreq_ready) begin
                m_busy    = 1;
                m_drop    = 0;
                m_rd_addr = m_pc;
                m_delay   = $urandom_range(0, 2);
            end
            if (pop) m_cnt--;
        end
        m_run = 1;
        train();
    endtask

    task automatic drive(input int p_redir, input int p_ready, input int p_mready, input int p_br);
        ireq.valid   = ($urandom_range(0, 99) < p_redir);
        ireq.addr    = rand_addr();
        iresp_ready  = ($urandom_range(0, 99) < p_ready);
        memreq_ready = ($urandom_range(0, 99) < p_mready);
        if (m_busy && m_delay == 0) begin
            memresp.valid = 1'b1;
            memresp.rdata = mem_data(m_rd_addr);
        end else begin
            memresp.valid = 1'b0;
            memresp.rdata = $urandom();
            if (m_busy) m_delay--;
        end
        brinfo.valid  = ($urandom_range(0, 99) < p_br);
        brinfo.pc     = rand_addr();
        brinfo.taken  = $urandom_range(0, 2) != 0;
        brinfo.target = rand_addr();
    endtask

    task automatic check_cycle();
        bit exp_mv = m_run && !m_busy && (m_cnt < DEPTH) && !ireq.valid;
        check("memreq_valid", 32'(memreq.valid), 32'(exp_mv));
        if (exp_mv) check("memreq_addr", memreq.addr, m_pc);
        check("memreq_write", 32'(memreq.wen) | memreq.wdata, 32'h0);
        check("iresp_valid", 32'(iresp.valid), 32'((m_cnt > 0) && !ireq.valid));
    endtask

    // Monitor: every accepted response must match the oldest expected entry.
    initial begin
        FetchEntry e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && iresp.valid && iresp_ready) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL iresp_unexpected: got addr %h, expected no output", iresp.addr);
                end else begin
                    e = sb_q.pop_front();
                    check("iresp_addr", iresp.addr, e.addr);
                    check("iresp_inst", iresp.inst, e.inst);
                    check("iresp_pred_next", iresp.pred_next, e.pred_next);
                end
            end
        end
    end

    int phase_cfg [3][4] = '{'{3, 80, 80, 25}, '{2, 20, 70, 30}, '{8, 60, 50, 40}};

    initial begin
        for (int i = 0; i < BTB; i++) begin
            b_valid[i] = 0;
            b_tag[i]   = 0;
            b_tgt[i]   = 0;
            b_ctr[i]   = 0;
        end
        rst_n        = 1'b0;
        ireq         = '0;
        iresp_ready  = 1'b1;
        memreq_ready = 1'b1;
        memresp      = '0;
        brinfo       = '0;
        #2;
        check("reset_memreq_valid", 32'(memreq.valid), 32'h0);
        check("reset_iresp_valid", 32'(iresp.valid), 32'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        drive(0, 80, 100, 0);
        #3 check_cycle();
        for (int p = 0; p < 3; p++) begin
            for (int c = 0; c < 1500; c++) begin
                @(posedge clk);
                model_update();
                #1 drive(phase_cfg[p][0], phase_cfg[p][1], phase_cfg[p][2], phase_cfg[p][3]);
                #3 check_cycle();
            end
        end
        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
